// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage feeding instruction_decoder. Owns the program counter and issues
// one word read at a time to instruction memory over a req/ready handshake.
// The returned word is held in the instruction register (instruction_set) for
// the decoder. Taken B/BL branches reported back from decode/execute redirect
// the fetch PC, and a BL also produces the R14 link value and a write strobe.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   imem_req          : read request, high only in FETCH and never during reset
//   imem_addr         : word-aligned read address (the fetch PC)
//   imem_ready        : memory response, imem_rdata valid in the same cycle
//   imem_rdata        : instruction word from memory
//   stall             : downstream cannot take the current instruction
//   branch_taken      : current instruction is a taken B/BL
//   branch_link       : the taken branch is a BL
//   branch_offset     : raw 24-bit branch offset field
//   instruction_set   : instruction register to the decoder
//   instr_valid       : instruction_set holds a live instruction
//   pc_out            : address of the instruction in instruction_set
//   link_addr         : BL return address (branch address + 4)
//   link_we           : one-cycle R14 write strobe after a taken BL
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        branch_link,
  input  logic [23:0] branch_offset,
  output logic [31:0] instruction_set,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] link_addr,
  output logic        link_we
);

  localparam logic S_FETCH = 1'b0;
  localparam logic S_ISSUE = 1'b1;

  logic        state_q,       state_d;
  logic [31:0] fetch_pc_q,    fetch_pc_d;
  logic [31:0] instr_q,       instr_d;
  logic [31:0] pc_out_q,      pc_out_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] link_addr_q,   link_addr_d;
  logic        link_we_q,     link_we_d;

  // Word displacement: sign-extend the 24-bit field and scale by 4, so the
  // target keeps bits [1:0] clear as long as pc_out is word aligned.
  logic [31:0] branch_disp;
  assign branch_disp = {{6{branch_offset[23]}}, branch_offset, 2'b00};

  // Gated with rst so the request drops the instant reset rises, abandoning
  // any in-flight read, rather than waiting for the state register.
  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the branches below leaves one unassigned (no latches).
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    link_addr_d   = link_addr_q;
    link_we_d     = 1'b0;  // strobe, only ever high for one cycle

    if (state_q == S_FETCH) begin
      // Branch/stall inputs are meaningless here: nothing live to act on.
      if (imem_ready) begin
        instr_d       = imem_rdata;
        pc_out_d      = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
        instr_valid_d = 1'b1;
        state_d       = S_ISSUE;
      end
    end else begin
      // ISSUE: a branch outranks a stall, since the branch consumes the
      // instruction and nothing on the sequential path may be presented.
      if (branch_taken) begin
        fetch_pc_d    = pc_out_q + 32'd8 + branch_disp;
        instr_valid_d = 1'b0;
        state_d       = S_FETCH;
        if (branch_link) begin
          link_addr_d = pc_out_q + 32'd4;
          link_we_d   = 1'b1;
        end
      end else if (!stall) begin
        // fetch_pc already points past this instruction.
        instr_valid_d = 1'b0;
        state_d       = S_FETCH;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= 32'h0;
      pc_out_q      <= 32'h0;
      instr_valid_q <= 1'b0;
      link_addr_q   <= 32'h0;
      link_we_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
      link_addr_q   <= link_addr_d;
      link_we_q     <= link_we_d;
    end
  end

  assign instruction_set = instr_q;
  assign pc_out          = pc_out_q;
  assign instr_valid     = instr_valid_q;
  assign link_addr       = link_addr_q;
  assign link_we         = link_we_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level reference model of the fetch stage. A second instance
// with RESET_PC = 0xFFFF_FFFC exercises address wrap-around.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        branch_link = 1'b0;
  logic [23:0] branch_offset = 24'h0;
  logic [31:0] instruction_set;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        link_we;

  // Wrap-around instance: always-ready memory, no branches, no stalls.
  logic        w_ready = 1'b1;
  logic [31:0] w_rdata = 32'h1234_5678;
  logic        w_zero  = 1'b0;
  logic [23:0] w_off   = 24'h0;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic        w_iv;
  logic [31:0] w_pc;
  logic [31:0] w_link;
  logic        w_lwe;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: where the stage is, what it is showing, what it owes.
  bit          m_fetch;   // waiting on memory (1) or presenting an instruction (0)
  logic [31:0] m_fpc;     // next address to read
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          m_iv;
  logic [31:0] m_link;
  bit          m_lwe;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_link(branch_link),
    .branch_offset(branch_offset),
    .instruction_set(instruction_set), .instr_valid(instr_valid),
    .pc_out(pc_out), .link_addr(link_addr), .link_we(link_we)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata),
    .stall(w_zero), .branch_taken(w_zero), .branch_link(w_zero),
    .branch_offset(w_off),
    .instruction_set(w_instr), .instr_valid(w_iv),
    .pc_out(w_pc), .link_addr(w_link), .link_we(w_lwe)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'hE087_5006 : a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/imem_req"},    {31'h0, imem_req},    {31'h0, m_fetch});
    if (m_fetch)
      check({tag, "/imem_addr"}, imem_addr, m_fpc);
    check({tag, "/instr_valid"}, {31'h0, instr_valid}, {31'h0, m_iv});
    check({tag, "/instr"},       instruction_set, m_instr);
    check({tag, "/pc_out"},      pc_out, m_pc);
    check({tag, "/link_we"},     {31'h0, link_we}, {31'h0, m_lwe});
    check({tag, "/link_addr"},   link_addr, m_link);
  endtask

  // One clock: drive inputs, predict from the rules, clock, compare.
  task automatic tick(input string tag, input logic rdy, input logic stl,
                      input logic bt, input logic bl, input logic [23:0] off);
    logic signed [31:0] soff;
    bit          n_fetch;
    logic [31:0] n_fpc, n_instr, n_pc, n_link;
    bit          n_iv, n_lwe;
    imem_ready    = rdy;
    stall         = stl;
    branch_taken  = bt;
    branch_link   = bl;
    branch_offset = off;
    imem_rdata    = mem_word(m_fpc);
    n_fetch = m_fetch; n_fpc = m_fpc; n_instr = m_instr; n_pc = m_pc;
    n_link = m_link; n_iv = m_iv; n_lwe = 0;
    if (m_fetch) begin
      if (rdy) begin
        n_instr = mem_word(m_fpc);
        n_pc    = m_fpc;
        n_fpc   = m_fpc + 32'd4;
        n_iv    = 1;
        n_fetch = 0;
      end
    end else if (bt) begin
      soff    = $signed(off);
      n_fpc   = m_pc + 32'd8 + 32'(soff * 4);
      n_iv    = 0;
      n_fetch = 1;
      if (bl) begin
        n_link = m_pc + 32'd4;
        n_lwe  = 1;
      end
    end else if (!stl) begin
      n_iv    = 0;
      n_fetch = 1;
    end
    @(posedge clk);
    #1;
    m_fetch = n_fetch; m_fpc = n_fpc; m_instr = n_instr; m_pc = n_pc;
    m_link = n_link; m_iv = n_iv; m_lwe = n_lwe;
    check_all(tag);
  endtask

  // Assert reset off-edge, verify the asynchronous clear, release on negedge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_link = 1'b0;
    #1;
    m_fetch = 1; m_fpc = 32'h0; m_instr = 32'h0; m_pc = 32'h0;
    m_iv = 0; m_link = 32'h0; m_lwe = 0;
    check({tag, "/rst_req"},   {31'h0, imem_req},    32'h0);
    check({tag, "/rst_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "/rst_lwe"},   {31'h0, link_we},     32'h0);
    check({tag, "/rst_pc"},    pc_out,               32'h0);
    check({tag, "/rst_instr"}, instruction_set,      32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all({tag, "/released"});
  endtask

  task automatic run_until_pc(input string tag, input logic [31:0] target);
    int n = 0;
    while (!(!m_fetch && m_pc == target) && n < 300) begin
      tick(tag, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      n++;
    end
    check({tag, "/reach_pc"}, {31'h0, (!m_fetch && m_pc == target)}, 32'h1);
  endtask

  initial begin
    // Settle both instances in reset before the first measured reset.
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");
    check("wrap/addr0", w_addr, 32'hFFFF_FFFC);

    // Sequential, zero-wait: addresses 0,4,8 and valid every other cycle.
    tick("seq", 1, 0, 0, 0, 24'h0);
    check("wrap/pc0", w_pc, 32'hFFFF_FFFC);
    tick("seq", 1, 0, 0, 0, 24'h0);
    check("wrap/addr1", w_addr, 32'h0);
    check("wrap/req1", {31'h0, w_req}, 32'h1);
    for (int i = 0; i < 4; i++) tick("seq", 1, 0, 0, 0, 24'h0);
    check("seq/pc8", pc_out, 32'h8);

    // Wait states: address 4 held through 3 not-ready cycles.
    do_reset("wait");
    tick("wait", 1, 0, 0, 0, 24'h0);
    tick("wait", 1, 0, 0, 0, 24'h0);
    for (int i = 0; i < 3; i++) tick("wait", 0, 0, 0, 0, 24'h0);
    check("wait/addr_held", imem_addr, 32'h4);
    tick("wait", 1, 0, 0, 0, 24'h0);

    // Stall at 0x10 for 3 cycles, then the next fetch is 0x14.
    do_reset("stall");
    run_until_pc("stall", 32'h10);
    for (int i = 0; i < 3; i++) tick("stall", 1, 1, 0, 0, 24'h0);
    check("stall/instr", instruction_set, 32'hE087_5006);
    tick("stall", 1, 0, 0, 0, 24'h0);
    check("stall/next", imem_addr, 32'h14);

    // BL at 0x20 with offset -2 words: target 0x20, link 0x24.
    run_until_pc("bl", 32'h20);
    tick("bl", 1, 0, 1, 1, 24'hFFFFFE);
    check("bl/target", imem_addr, 32'h20);
    check("bl/link", link_addr, 32'h24);
    check("bl/we", {31'h0, link_we}, 32'h1);
    tick("bl", 0, 0, 0, 0, 24'h0);

    // Jump to 0x100, then forward branch +3 words to 0x114 with no link.
    tick("fwd", 1, 0, 0, 0, 24'h0);
    tick("fwd", 1, 0, 1, 0, 24'h000036);
    run_until_pc("fwd", 32'h100);
    tick("fwd", 1, 0, 1, 0, 24'h000003);
    check("fwd/target", imem_addr, 32'h114);
    check("fwd/we", {31'h0, link_we}, 32'h0);

    // Branch and stall together: branch wins.
    run_until_pc("prio", 32'h114);
    tick("prio", 1, 1, 1, 0, 24'h000010);
    check("prio/target", imem_addr, 32'h15C);

    // Reset during a FETCH wait state, then during a stalled ISSUE.
    tick("midrst", 0, 0, 0, 0, 24'h0);
    tick("midrst", 0, 0, 0, 0, 24'h0);
    do_reset("rst_fetch");
    tick("midrst", 1, 0, 0, 0, 24'h0);
    tick("midrst", 1, 1, 0, 0, 24'h0);
    do_reset("rst_issue");
    tick("midrst", 1, 0, 0, 0, 24'h0);

    // Random traffic, including ready and branch inputs in the wrong state.
    for (int i = 0; i < 400; i++) begin
      logic r, s, b, l;
      logic [23:0] o;
      r = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 3) == 0);
      l = $urandom_range(0, 1) == 1;
      o = 24'($urandom);
      tick("rand", r, s, b, l, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage directly upstream of `instruction_decoder`. It owns the program counter and issues one word read at a time to instruction memory with a req/ready handshake. It holds the fetched word in an instruction register that drives the decoder's `instruction_set` input. It resolves taken branches (B/BL) reported back from the decode/execute side and produces the BL link value for R14.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Must be word aligned.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `imem_req`, output, 1: read request to instruction memory.
- `imem_addr`, output, 32: word-aligned read address. Valid while `imem_req`=1.
- `imem_ready`, input, 1: memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata`, input, 32: instruction word.
- `stall`, input, 1: downstream cannot accept the current instruction; hold it.
- `branch_taken`, input, 1: the current instruction is a B/BL that passed its condition check. Honoured only when `instr_valid`=1.
- `branch_link`, input, 1: the taken branch is BL. Qualified by `branch_taken`.
- `branch_offset`, input, 24: raw offset field, bits [23:0] of the branch.
- `instruction_set`, output, 32: instruction register, connected to the decoder.
- `instr_valid`, output, 1: `instruction_set` holds a live instruction. Connected to the decoder `enable`.
- `pc_out`, output, 32: address of the instruction in `instruction_set`.
- `link_addr`, output, 32: BL return address.
- `link_we`, output, 1: one-cycle write strobe for R14.

## Operation
- Two-state FSM with states FETCH and ISSUE. Internal `fetch_pc`, 32 bits.
- Reset, asserted asynchronously:
  - state is FETCH and `fetch_pc` is RESET_PC.
  - `instr_valid`, `link_we` are 0.
  - `instruction_set`, `pc_out`, `link_addr` are 0.
  - `imem_req` drops to 0 immediately and stays 0 while `rst`=1. Any in-flight request is abandoned.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`fetch_pc`, both combinational from state.
  - The address is held stable until `imem_ready`.
  - On `imem_ready`: `instruction_set`←`imem_rdata`, `pc_out`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4, `instr_valid`←1, go to ISSUE.
- ISSUE:
  - `imem_req`=0.
  - Priority order: branch_taken, then stall, then advance.
  - `branch_taken`=1:
    - `fetch_pc`←`pc_out` + 8 + (sign_extend(`branch_offset`) << 2).
    - `instr_valid`←0, go to FETCH.
    - If `branch_link`: `link_addr`←`pc_out`+4 and `link_we`←1 for exactly one cycle.
  - `stall`=1 and no branch: hold all state, with `instruction_set`, `pc_out` and `instr_valid` unchanged.
  - Otherwise: `instr_valid`←0, go to FETCH. Sequential `fetch_pc` was already incremented.
- Arithmetic:
  - All PC math is modulo 2^32. 0xFFFF_FFFC+4 wraps to 0.
  - Branch target: the offset is sign-extended to 32 bits, then shifted left 2; bits [1:0] of the target are always 0.
- Signals ignored in FETCH: `branch_taken`, `branch_link`, `stall` (no live instruction).
- `imem_ready` asserted in ISSUE is ignored; the memory must not respond without a request.
- `link_we` is 0 in every cycle except the one following a taken BL.

## Timing
- `imem_ready` sampled high at edge N: `instr_valid`=1 and new `instruction_set` visible after edge N.
- Minimum instruction period is 2 cycles (one FETCH, one ISSUE) with a zero-wait memory. Each memory wait cycle adds one.
- Taken branch at edge N: FETCH with `imem_addr`=target in the cycle after edge N. `link_we` is high during that same cycle.
- The branch instruction is consumed in its ISSUE cycle; no wrong-path instruction is ever presented.
- Stall has no latency: the register holds on the same edge `stall` is sampled.
- Reset deassertion: first `imem_req`=1 with `imem_addr`=RESET_PC in the first cycle after `rst` falls.

## Test plan
- Reset/sequential, zero-wait memory returning the word equal to its address:
  - After `rst` falls, `imem_addr` steps 0,4,8.
  - `instr_valid` pulses every other cycle.
  - `pc_out` reads 0,4,8; `instruction_set` tracks it.
- Wait states: `imem_ready` delayed 3 cycles. `imem_addr` stays 0x4 for all 4 request cycles; `instr_valid` stays 0 until the cycle after ready.
- Stall:
  - `instruction_set`=0xE0875006 at `pc_out`=0x10, `stall` high 3 cycles.
  - Outputs hold for 3 cycles; `imem_req`=0 throughout.
  - The next fetch is 0x14.
- Branch and link:
  - At `pc_out`=0x20: `branch_taken`=1, `branch_link`=1, `branch_offset`=24'hFFFFFE (−2 words).
  - Next `imem_addr`=0x20 (0x20+8−8).
  - `link_we`=1 for one cycle with `link_addr`=0x24.
- Forward branch and wrap:
  - `pc_out`=0x100, offset 24'h000003: next fetch is 0x114, `link_we`=0.
  - Separately, RESET_PC=0xFFFF_FFFC: second fetch address is 0x0.
- Reset mid-operation:
  - Assert `rst` during a FETCH wait state and mid-ISSUE with `stall`=1.
  - `imem_req`, `instr_valid` and `link_we` fall asynchronously before the next edge; `pc_out` and `instruction_set` read 0.
  - Fetch restarts at RESET_PC.
- Branch-over-stall priority: `branch_taken`=1 and `stall`=1 in the same ISSUE cycle. The branch is taken and the FSM goes to FETCH the next cycle.
